// File: rtl/maquina_control_param.sv
// Parametrised supervisor for the FIFO transaction path: tracks FIFO empty/error
// flags, latches thresholds during INIT and reports a one-hot global state.

package maquina_control_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

endpackage

module maquina_control_param
  import maquina_control_pkg::*;
#(
  parameter int                   NUM_FIFOS = 5,
  parameter int                   BITBUS    = 4,
  parameter int                   ERR_HOLD  = 2,
  parameter int                   CNT_W     = 4,
  parameter logic [NUM_FIFOS-1:0] ERR_MASK  = '1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [BITBUS-1:0]    umbralMF,
  input  logic [BITBUS-1:0]    umbralVC,
  input  logic [BITBUS-1:0]    umbralD,
  input  logic [NUM_FIFOS-1:0] Fifo_empties,
  input  logic [NUM_FIFOS-1:0] Fifo_errors,
  output logic                 init_out,
  output logic                 idle_out,
  output logic                 active_out,
  output logic                 error_out,
  output logic [BITBUS-1:0]    umbralMF_out,
  output logic [BITBUS-1:0]    umbralVC_out,
  output logic [BITBUS-1:0]    umbralD_out,
  output logic [NUM_FIFOS-1:0] error_fifos,
  output logic [CNT_W-1:0]     error_count,
  output logic [2:0]           state_out
);

  // The hold counter only ever needs to reach ERR_HOLD-1.
  localparam int               HOLD_W    = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ERR_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_t                 state, state_next;
  logic [HOLD_W-1:0]      hold_cnt, hold_next;
  logic [NUM_FIFOS-1:0]   masked_err;
  logic                   err;
  logic                   all_empty;
  logic                   load_thr;
  logic                   count_inc;

  assign masked_err = Fifo_errors & ERR_MASK;
  assign err        = |masked_err;
  assign all_empty  = &Fifo_empties;

  // Next-state logic. Any error in an operational state pre-empts every
  // other transition, including an init request.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    state_next = state;
    hold_next  = '0;
    load_thr   = 1'b0;
    count_inc  = 1'b0;
    unique case (state)
      ST_RESET: state_next = ST_INIT;
      ST_INIT: begin
        load_thr = 1'b1;
        if (err) begin
          state_next = ST_ERROR;
          count_inc  = 1'b1;
        end else if (!init) begin
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (err) begin
          state_next = ST_ERROR;
          count_inc  = 1'b1;
        end else if (init) begin
          state_next = ST_INIT;
        end else if (!all_empty) begin
          state_next = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (err) begin
          state_next = ST_ERROR;
          count_inc  = 1'b1;
        end else if (all_empty) begin
          state_next = ST_IDLE;
        end
      end
      ST_ERROR: begin
        // A re-asserted error restarts the dwell; leaving ERROR passes through
        // RESET so that INIT reloads the thresholds.
        if (err) begin
          hold_next = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next = ST_RESET;
        end else begin
          hold_next = hold_cnt + HOLD_ONE;
        end
      end
      default: state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      state        <= ST_RESET;
      hold_cnt     <= '0;
      umbralMF_out <= '0;
      umbralVC_out <= '0;
      umbralD_out  <= '0;
      error_fifos  <= '0;
      error_count  <= '0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_next;
      error_fifos <= error_fifos | masked_err;
      if (load_thr) begin
        umbralMF_out <= umbralMF;
        umbralVC_out <= umbralVC;
        umbralD_out  <= umbralD;
      end
      if (count_inc && (error_count != '1)) begin
        error_count <= error_count + CNT_ONE;
      end
    end
  end

  // Moore decode of the state register; RESET drives no flag.
  assign init_out   = (state == ST_INIT);
  assign idle_out   = (state == ST_IDLE);
  assign active_out = (state == ST_ACTIVE);
  assign error_out  = (state == ST_ERROR);
  assign state_out  = state;

endmodule

// File: tb/tb_maquina_control_param.sv
// Self-checking bench for maquina_control_param: two instances (full mask and
// FIFO0 masked) run side by side against a behavioural model of the rules.

module tb_maquina_control_param;

  localparam int ERR_HOLD = 2;
  localparam logic [4:0] MASK_A = 5'b11111;
  localparam logic [4:0] MASK_B = 5'b11110;

  logic       clk = 1'b0;
  logic       reset, init;
  logic [3:0] umbral_mf, umbral_vc, umbral_d;
  logic [4:0] fifo_empties, fifo_errors;

  logic       init_a, idle_a, active_a, error_a;
  logic [3:0] mf_a, vc_a, d_a, cnt_a;
  logic [4:0] ef_a;
  logic [2:0] st_a;
  logic       init_b, idle_b, active_b, error_b;
  logic [3:0] mf_b, vc_b, d_b, cnt_b;
  logic [4:0] ef_b;
  logic [2:0] st_b;

  logic [27:0] obs_a, obs_b;
  assign obs_a = {st_a, init_a, idle_a, active_a, error_a, mf_a, vc_a, d_a, ef_a, cnt_a};
  assign obs_b = {st_b, init_b, idle_b, active_b, error_b, mf_b, vc_b, d_b, ef_b, cnt_b};

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  maquina_control_param #(.NUM_FIFOS(5), .BITBUS(4), .ERR_HOLD(ERR_HOLD), .CNT_W(4),
                          .ERR_MASK(MASK_A)) u_dut_a (
    .clk(clk), .reset(reset), .init(init),
    .umbralMF(umbral_mf), .umbralVC(umbral_vc), .umbralD(umbral_d),
    .Fifo_empties(fifo_empties), .Fifo_errors(fifo_errors),
    .init_out(init_a), .idle_out(idle_a), .active_out(active_a), .error_out(error_a),
    .umbralMF_out(mf_a), .umbralVC_out(vc_a), .umbralD_out(d_a),
    .error_fifos(ef_a), .error_count(cnt_a), .state_out(st_a)
  );

  maquina_control_param #(.NUM_FIFOS(5), .BITBUS(4), .ERR_HOLD(ERR_HOLD), .CNT_W(4),
                          .ERR_MASK(MASK_B)) u_dut_b (
    .clk(clk), .reset(reset), .init(init),
    .umbralMF(umbral_mf), .umbralVC(umbral_vc), .umbralD(umbral_d),
    .Fifo_empties(fifo_empties), .Fifo_errors(fifo_errors),
    .init_out(init_b), .idle_out(idle_b), .active_out(active_b), .error_out(error_b),
    .umbralMF_out(mf_b), .umbralVC_out(vc_b), .umbralD_out(d_b),
    .error_fifos(ef_b), .error_count(cnt_b), .state_out(st_b)
  );

  // Behavioural model: st uses the published codes, clean counts consecutive
  // error-free edges spent in ERROR.
  typedef struct {
    int         st;
    logic [3:0] mf, vc, d;
    logic [4:0] ef;
    int         cnt;
    int         clean;
  } model_t;

  model_t m_a, m_b;

  function automatic model_t step(model_t m, logic [4:0] mask);
    model_t n;
    logic   err;
    logic   all_empty;
    n         = m;
    err       = |(fifo_errors & mask);
    all_empty = &fifo_empties;
    if (!reset) begin
      n.st = 0; n.mf = 0; n.vc = 0; n.d = 0; n.ef = 0; n.cnt = 0; n.clean = 0;
      return n;
    end
    n.ef = m.ef | (fifo_errors & mask);
    if (m.st == 1) begin
      n.mf = umbral_mf; n.vc = umbral_vc; n.d = umbral_d;
    end
    if ((m.st >= 1) && (m.st <= 3) && err) begin
      n.st = 4; n.clean = 0;
      if (m.cnt < 15) n.cnt = m.cnt + 1;
    end else begin
      case (m.st)
        0: n.st = 1;
        1: if (!init) n.st = 2;
        2: if (init) n.st = 1; else if (!all_empty) n.st = 3;
        3: if (all_empty) n.st = 2;
        default: begin
          if (err) n.clean = 0;
          else begin
            n.clean = m.clean + 1;
            if (n.clean >= ERR_HOLD) begin n.st = 0; n.clean = 0; end
          end
        end
      endcase
    end
    return n;
  endfunction

  function automatic logic [27:0] expect_vec(model_t m);
    return {3'(m.st), m.st == 1, m.st == 2, m.st == 3, m.st == 4,
            m.mf, m.vc, m.d, m.ef, 4'(m.cnt)};
  endfunction

  // Advance one edge: models sample the same inputs the DUTs see.
  task automatic tick();
    @(posedge clk);
    m_a = step(m_a, MASK_A);
    m_b = step(m_b, MASK_B);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; init = 1'b1; umbral_mf = 4'hF; umbral_vc = 4'hF; umbral_d = 4'hF;
    fifo_empties = 5'b00000; fifo_errors = 5'b11111;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs_a !== 28'h0) begin failures++; $display("FAIL reset_a: got %h expected 0", obs_a); end
      checks++;
      if (obs_b !== 28'h0) begin failures++; $display("FAIL reset_b: got %h expected 0", obs_b); end
    end
  endtask

  task automatic test_init();
    reset = 1'b1; init = 1'b1; umbral_mf = 4'd3; umbral_vc = 4'd5; umbral_d = 4'd7;
    fifo_empties = 5'b11111; fifo_errors = 5'b00000;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({init_a, st_a} !== {1'b1, 3'd1}) begin
        failures++; $display("FAIL init_hold[%0d]: got init_out=%b state=%0d expected 1/1", i, init_a, st_a);
      end
    end
    init = 1'b0;
    tick();
    checks++;
    if ({idle_a, st_a} !== {1'b1, 3'd2}) begin
      failures++; $display("FAIL init_to_idle: got idle_out=%b state=%0d expected 1/2", idle_a, st_a);
    end
    checks++;
    if ({mf_a, vc_a, d_a} !== {4'd3, 4'd5, 4'd7}) begin
      failures++; $display("FAIL thresholds: got %0d/%0d/%0d expected 3/5/7", mf_a, vc_a, d_a);
    end
    checks++;
    if (obs_b !== expect_vec(m_b)) begin failures++; $display("FAIL init_model_b: got %h expected %h", obs_b, expect_vec(m_b)); end
  endtask

  task automatic test_activity();
    logic [4:0] pat [3] = '{5'b11001, 5'b10001, 5'b11111};
    logic [2:0] exp_st [3] = '{3'd3, 3'd3, 3'd2};
    for (int i = 0; i < 3; i++) begin
      fifo_empties = pat[i];
      tick();
      checks++;
      if (st_a !== exp_st[i]) begin
        failures++; $display("FAIL activity[%0d]: got state=%0d expected %0d", i, st_a, exp_st[i]);
      end
      checks++;
      if (obs_a !== expect_vec(m_a)) begin failures++; $display("FAIL activity_model[%0d]: got %h expected %h", i, obs_a, expect_vec(m_a)); end
    end
  endtask

  task automatic test_error_recovery();
    int clean_edges;
    fifo_empties = 5'b11001;
    tick();
    fifo_errors = 5'b00001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (error_a !== 1'b1) begin failures++; $display("FAIL err_entry[%0d]: got error_out=%b expected 1", i, error_a); end
      checks++;
      if ({active_b, ef_b} !== {1'b1, 5'b00000}) begin
        failures++; $display("FAIL mask_ignored[%0d]: got active=%b error_fifos=%b expected 1/00000", i, active_b, ef_b);
      end
    end
    fifo_errors = 5'b00000;
    umbral_mf = 4'd9; umbral_vc = 4'd10; umbral_d = 4'd11;
    clean_edges = 0;
    while (error_a === 1'b1 && clean_edges < 20) begin
      tick();
      clean_edges++;
    end
    checks++;
    if (clean_edges !== ERR_HOLD) begin
      failures++; $display("FAIL err_dwell: got %0d clean edges expected %0d", clean_edges, ERR_HOLD);
    end
    checks++;
    if (obs_a[27:21] !== 7'b0000000) begin failures++; $display("FAIL err_to_reset: got state/flags %b expected 0", obs_a[27:21]); end
    checks++;
    if ({ef_a, cnt_a} !== {5'b00001, 4'd1}) begin
      failures++; $display("FAIL err_record: got error_fifos=%b count=%0d expected 00001/1", ef_a, cnt_a);
    end
    tick();
    checks++;
    if (init_a !== 1'b1) begin failures++; $display("FAIL err_to_init: got init_out=%b expected 1", init_a); end
    fifo_empties = 5'b11111;
    tick();
    checks++;
    if ({idle_a, mf_a, vc_a, d_a} !== {1'b1, 4'd9, 4'd10, 4'd11}) begin
      failures++; $display("FAIL reload: got idle=%b %0d/%0d/%0d expected 1 9/10/11", idle_a, mf_a, vc_a, d_a);
    end
    checks++;
    if (obs_b !== expect_vec(m_b)) begin failures++; $display("FAIL err_model_b: got %h expected %h", obs_b, expect_vec(m_b)); end
  endtask

  task automatic test_dwell_restart();
    logic [4:0] seq [4] = '{5'b00010, 5'b00000, 5'b00010, 5'b00000};
    for (int i = 0; i < 4; i++) begin
      fifo_errors = seq[i];
      tick();
      checks++;
      if ({error_a, cnt_a} !== {1'b1, 4'd2}) begin
        failures++; $display("FAIL dwell[%0d]: got error_out=%b count=%0d expected 1/2", i, error_a, cnt_a);
      end
    end
    tick();
    checks++;
    if (st_a !== 3'd0) begin failures++; $display("FAIL dwell_exit: got state=%0d expected 0", st_a); end
    tick();
    tick();
    // IDLE: init beats a not-empty request.
    init = 1'b1; fifo_empties = 5'b11001;
    tick();
    checks++;
    if (st_a !== 3'd1) begin failures++; $display("FAIL init_priority: got state=%0d expected 1", st_a); end
    init = 1'b0; fifo_empties = 5'b11111;
    tick();
    // IDLE: error beats init.
    init = 1'b1; fifo_errors = 5'b00100;
    tick();
    checks++;
    if ({st_a, st_b} !== {3'd4, 3'd4}) begin
      failures++; $display("FAIL err_priority: got states %0d/%0d expected 4/4", st_a, st_b);
    end
    init = 1'b0; fifo_errors = 5'b00000;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (obs_a !== expect_vec(m_a)) begin failures++; $display("FAIL dwell_model_a: got %h expected %h", obs_a, expect_vec(m_a)); end
    checks++;
    if (obs_b !== expect_vec(m_b)) begin failures++; $display("FAIL dwell_model_b: got %h expected %h", obs_b, expect_vec(m_b)); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 17; k++) begin
      fifo_errors = 5'b00001;
      tick();
      checks++;
      if (error_a !== 1'b1) begin failures++; $display("FAIL sat_entry[%0d]: got error_out=%b expected 1", k, error_a); end
      fifo_errors = 5'b00000;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (obs_a !== expect_vec(m_a)) begin failures++; $display("FAIL sat_model[%0d]: got %h expected %h", k, obs_a, expect_vec(m_a)); end
    end
    checks++;
    if (cnt_a !== 4'd15) begin failures++; $display("FAIL saturate: got count=%0d expected 15", cnt_a); end
    checks++;
    if ({cnt_b, ef_b} !== {4'd2, 5'b00110}) begin
      failures++; $display("FAIL mask_count: got count=%0d error_fifos=%b expected 2/00110", cnt_b, ef_b);
    end
  endtask

  task automatic test_mid_reset();
    fifo_empties = 5'b10101;
    tick();
    checks++;
    if (active_a !== 1'b1) begin failures++; $display("FAIL pre_reset_active: got active_out=%b expected 1", active_a); end
    reset = 1'b0;
    tick();
    checks++;
    if (obs_a !== 28'h0) begin failures++; $display("FAIL mid_reset: got %h expected 0", obs_a); end
    reset = 1'b1;
    tick();
    checks++;
    if ({init_a, st_a} !== {1'b1, 3'd1}) begin
      failures++; $display("FAIL reset_release: got init_out=%b state=%0d expected 1/1", init_a, st_a);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      reset        = ($urandom_range(0, 49) != 0);
      init         = ($urandom_range(0, 4) == 0);
      umbral_mf    = 4'($urandom);
      umbral_vc    = 4'($urandom);
      umbral_d     = 4'($urandom);
      fifo_empties = ($urandom_range(0, 1) == 1) ? 5'b11111 : 5'($urandom);
      fifo_errors  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'b00000;
      tick();
      checks++;
      if (obs_a !== expect_vec(m_a)) begin failures++; $display("FAIL rand_a[%0d]: got %h expected %h", i, obs_a, expect_vec(m_a)); end
      checks++;
      if (obs_b !== expect_vec(m_b)) begin failures++; $display("FAIL rand_b[%0d]: got %h expected %h", i, obs_b, expect_vec(m_b)); end
    end
  endtask

  initial begin
    m_a = '{st: 0, mf: 4'd0, vc: 4'd0, d: 4'd0, ef: 5'd0, cnt: 0, clean: 0};
    m_b = m_a;
    test_reset();
    test_init();
    test_activity();
    test_error_recovery();
    test_dwell_restart();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
